buffer_pipe_hs: RTL

BUFFER_PIPE_HS -- requirements
Module: buffer_pipe_hs

---
 rtl/buffer_pipe_pkg.sv | 22 ++
 rtl/buffer_pipe_reg.sv | 20 ++
 rtl/buffer_pipe_hs.sv | 113 +++++++++++
 3 files changed

// File: rtl/buffer_pipe_pkg.sv
// Shared types and defaults for the two-entry skid buffer pipeline stage.
package buffer_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_LANES = 16;
  localparam int unsigned OCC_W         = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      ST_BUSY: occ_of = OCC_W'(1);
      ST_FULL: occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/buffer_pipe_reg.sv
// Enable register with synchronous active-low clear to zero.
module buffer_pipe_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/buffer_pipe_hs.sv
// Valid/ready pipeline stage with an output register plus one skid register,
// giving full throughput while in_ready comes straight from a flop.
module buffer_pipe_hs
  import buffer_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LANES = DEFAULT_LANES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]       occ
);

  localparam int unsigned DATA_W = LANES * WIDTH;

  state_t              state;
  state_t              state_next;
  logic                in_fire;
  logic                out_fire;
  logic                out_load;
  logic                skid_load;
  logic                use_skid;
  logic                in_ready_d;
  logic                out_valid_d;
  logic [OCC_W-1:0]    occ_d;
  logic [DATA_W-1:0]   out_d;
  logic [DATA_W-1:0]   skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State plus the status flags decoded from it, all held in flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occ       <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      occ       <= occ_d;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state_next = ST_BUSY;
        ST_BUSY: begin
          if (in_fire && !out_fire)      state_next = ST_FULL;
          else if (!in_fire && out_fire) state_next = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_next = ST_BUSY;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Flush blocks every register load so held data stays put.
  always_comb begin
    out_load    = 1'b0;
    skid_load   = 1'b0;
    use_skid    = 1'b0;
    in_ready_d  = (state_next != ST_FULL);
    out_valid_d = (state_next != ST_EMPTY);
    occ_d       = occ_of(state_next);
    if (!flush) begin
      case (state)
        ST_EMPTY: out_load = in_fire;
        ST_BUSY: begin
          out_load  = in_fire & out_fire;
          skid_load = in_fire & ~out_fire;
        end
        ST_FULL: begin
          out_load = out_fire;
          use_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_d = use_skid ? skid_q : in_data;

  buffer_pipe_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (out_load),
    .d     (out_d),
    .q     (out_data)
  );

  buffer_pipe_reg #(.DATA_W(DATA_W)) u_skid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
